// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: operand sizes, writeback FSM states, command bundle.
// The optional TA fill is enabled with RISCV_V_TAIL_AGNOSTIC_FILL_EN.
package riscv_v_pkg;

  localparam int RISCV_V_DATA_W         = 128;
  localparam int RISCV_V_NUM_BYTES_DATA = RISCV_V_DATA_W / 8;
  localparam int RISCV_V_VL_W           = 8;
  localparam int RISCV_V_VREG_W         = 5;

  typedef enum logic [2:0] {
    OSIZE_8   = 3'd0,
    OSIZE_16  = 3'd1,
    OSIZE_32  = 3'd2,
    OSIZE_64  = 3'd3,
    OSIZE_128 = 3'd4
  } riscv_v_osize_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } riscv_v_wb_state_e;

  typedef struct packed {
    logic [RISCV_V_VREG_W-1:0] vd;
    riscv_v_osize_e            osize;
    logic [3:0]                nregs;
    logic [RISCV_V_VL_W-1:0]   vl;
    logic [RISCV_V_VL_W-1:0]   vstart;
    logic                      vta;
  } riscv_v_wb_cmd_t;

endpackage

// File: rtl/riscv_v_wb_be_gen.sv
// Byte-enable generator: classifies each byte of a beat as body/prestart/tail.
// RISCV_V_TAIL_AGNOSTIC_FILL_EN lets vta turn tail bytes into enabled writes.
module riscv_v_wb_be_gen
  import riscv_v_pkg::*;
#(
  parameter int NUM_BYTES = RISCV_V_NUM_BYTES_DATA,
  parameter int VL_W      = RISCV_V_VL_W
) (
  input  logic [2:0]           reg_idx_i,
  input  riscv_v_osize_e       osize_i,
  input  logic [VL_W-1:0]      vl_i,
  input  logic [VL_W-1:0]      vstart_i,
  input  logic                 vta_i,
  output logic [NUM_BYTES-1:0] be_o,
  output logic [NUM_BYTES-1:0] tail_o
);

  localparam int LB = $clog2(NUM_BYTES);

  logic [NUM_BYTES-1:0] body;
  int unsigned          os;
  int unsigned          e;

  always_comb begin
    body   = '0;
    tail_o = '0;
    os     = (int'(osize_i) > LB) ? LB : int'(osize_i);
    e      = 0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      // element index of byte b within the whole register group
      e = (int'(reg_idx_i) << (LB - os)) + (b >> os);
      body[b]   = (e >= int'(vstart_i)) && (e < int'(vl_i));
      tail_o[b] = (e >= int'(vl_i)) && (e >= int'(vstart_i));
    end
  end

`ifdef RISCV_V_TAIL_AGNOSTIC_FILL_EN
  assign be_o = body | (tail_o & {NUM_BYTES{vta_i}});
`else
  logic vta_unused;
  assign vta_unused = vta_i;
  assign be_o = body;
`endif

endmodule

// File: rtl/riscv_v_writeback_element.sv
// Vector writeback: ALU result beats -> byte-enabled VRF writes over an LMUL group.
// RISCV_V_TAIL_AGNOSTIC_FILL_EN enables 0xFF tail fill when vta is set.
module riscv_v_writeback_element
  import riscv_v_pkg::*;
#(
  parameter int DATA_W    = RISCV_V_DATA_W,
  parameter int NUM_BYTES = DATA_W / 8,
  parameter int VL_W      = RISCV_V_VL_W,
  parameter int VREG_W    = RISCV_V_VREG_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_first,
  input  logic [VREG_W-1:0]    in_vd,
  input  logic [2:0]           in_osize,
  input  logic [3:0]           in_nregs,
  input  logic [VL_W-1:0]      in_vl,
  input  logic [VL_W-1:0]      in_vstart,
  input  logic                 in_vta,
  output logic                 vrf_wr_valid,
  input  logic                 vrf_wr_ready,
  output logic [VREG_W-1:0]    vrf_wr_addr,
  output logic [DATA_W-1:0]    vrf_wr_data,
  output logic [NUM_BYTES-1:0] vrf_wr_be,
  output logic                 done
);

  riscv_v_wb_state_e state_q, state_d;
  riscv_v_wb_cmd_t   cmd_q, cur;
  logic [2:0]        idx_q, idx_d, idx;

  logic                 first, accept, proc, last;
  logic [NUM_BYTES-1:0] be, tail, fill;
  logic [DATA_W-1:0]    wdata;

  logic                 valid_q, last_q;
  logic [VREG_W-1:0]    addr_q;
  logic [DATA_W-1:0]    data_q;
  logic [NUM_BYTES-1:0] be_q;

  // A new command only starts from IDLE; in_first is ignored mid-group.
  always_comb begin
    first = (state_q == IDLE) && in_first;
    cur   = cmd_q;
    idx   = idx_q;
    if (first) begin
      cur = '{vd: in_vd, osize: riscv_v_osize_e'(in_osize),
              nregs: in_nregs, vl: in_vl, vstart: in_vstart,
              vta: in_vta};
      idx = '0;
    end
  end

  assign accept = in_valid && in_ready;
  assign proc   = accept && ((state_q == BUSY) || first);
  assign last   = ({1'b0, idx} == (cur.nregs - 4'd1));

  riscv_v_wb_be_gen #(
    .NUM_BYTES(NUM_BYTES),
    .VL_W     (VL_W)
  ) u_be_gen (
    .reg_idx_i(idx),
    .osize_i  (cur.osize),
    .vl_i     (cur.vl),
    .vstart_i (cur.vstart),
    .vta_i    (cur.vta),
    .be_o     (be),
    .tail_o   (tail)
  );

`ifdef RISCV_V_TAIL_AGNOSTIC_FILL_EN
  assign fill = tail & {NUM_BYTES{cur.vta}};
`else
  logic tail_unused;
  assign tail_unused = ^tail;
  assign fill = '0;
`endif

  always_comb begin
    wdata = in_data;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (fill[b]) wdata[b*8 +: 8] = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (proc && first) cmd_q <= cur;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (proc) begin
      idx_d   = last ? 3'd0 : idx + 3'd1;
      state_d = last ? IDLE : BUSY;
    end
  end

  always_comb begin
    in_ready = !valid_q || vrf_wr_ready;
    done     = (valid_q && vrf_wr_ready && last_q)
            || (proc && !(|be) && last);
  end

  // Output slice: reload on accept, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else if (accept) begin
      valid_q <= proc && (|be);
      if (proc && (|be)) begin
        last_q <= last;
        addr_q <= cur.vd + {{(VREG_W-3){1'b0}}, idx};
        data_q <= wdata;
        be_q   <= be;
      end
    end else if (vrf_wr_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign vrf_wr_valid = valid_q;
  assign vrf_wr_addr  = addr_q;
  assign vrf_wr_data  = data_q;
  assign vrf_wr_be    = be_q;

endmodule
